// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache: 32 lines x 8 halfwords, filled from pipelined main memory.
// Latency: hits return in the same cycle; a miss stalls for 13 cycles (8 requests, MEM_LAT-cycle returns).
// Backpressure: stall holds the IF stage during a fill; memory is assumed to always accept and return.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   fetch_en, fetch_addr     fetch request and byte address (bit 0 ignored)
//   instr_out, stall         hit data (zero otherwise), pipeline hold
//   mem_rd_en, mem_addr      one-word-per-cycle read requests to main memory
//   mem_rvalid, mem_rdata    in-order return data
//   access_count, miss_count statistics, built only when ICACHE_STATS_EN is defined
module instr_cache #(
    parameter int LINES   = 32,
    parameter int MEM_LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic [15:0] fetch_addr,
    output logic [15:0] instr_out,
    output logic        stall,
    output logic        mem_rd_en,
    output logic [15:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [15:0] mem_rdata,
    output logic [15:0] access_count,
    output logic [15:0] miss_count
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 12 - IDX_W;

    // The fill sequencing assumes returns start only after requests have begun
    // and the last return lands after the last request.
    if (MEM_LAT < 1 || MEM_LAT > 8) begin : g_bad_mem_lat
        $error("instr_cache: MEM_LAT out of supported range");
    end

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    state_t             state_q;
    logic [LINES-1:0]   valid_q;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [15:0]        data_q [LINES][8];
    logic [11:0]        fill_base_q;
    logic [2:0]         req_cnt_q;
    logic [2:0]         ret_cnt_q;

    logic [TAG_W-1:0]   fetch_tag;
    logic [IDX_W-1:0]   fetch_idx;
    logic [2:0]         fetch_off;
    logic [IDX_W-1:0]   fill_idx;
    logic [TAG_W-1:0]   fill_tag;
    logic               hit;
    logic               ret_wr;
    logic               fill_done;
    logic               unused_addr_lsb;

    assign fetch_tag = fetch_addr[15:4+IDX_W];
    assign fetch_idx = fetch_addr[4 +: IDX_W];
    assign fetch_off = fetch_addr[3:1];
    assign fill_idx  = fill_base_q[IDX_W-1:0];
    assign fill_tag  = fill_base_q[11:IDX_W];
    assign unused_addr_lsb = fetch_addr[0];

    // Tag is compared only under a set valid bit, so the unreset tag array is harmless.
    assign hit       = fetch_en && valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag)
                       && (state_q == IDLE);
    assign instr_out = hit ? data_q[fetch_idx][fetch_off] : 16'h0000;
    assign stall     = (fetch_en && !hit) || (state_q != IDLE);

    // Returns are accepted only while a fill is in flight; stragglers after a reset are dropped.
    assign ret_wr    = (state_q != IDLE) && mem_rvalid;
    assign fill_done = ret_wr && (ret_cnt_q == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            fill_base_q <= '0;
            req_cnt_q   <= '0;
            ret_cnt_q   <= '0;
            mem_rd_en   <= 1'b0;
            mem_addr    <= 16'h0000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fetch_en && !hit) begin
                        fill_base_q <= fetch_addr[15:4];
                        req_cnt_q   <= 3'd0;
                        ret_cnt_q   <= 3'd0;
                        // First request goes out on the first FILL cycle.
                        mem_rd_en   <= 1'b1;
                        mem_addr    <= {fetch_addr[15:4], 4'b0000};
                        state_q     <= FILL;
                    end
                end
                FILL: begin
                    if (req_cnt_q == 3'd7) begin
                        mem_rd_en <= 1'b0;
                        mem_addr  <= 16'h0000;
                        state_q   <= DRAIN;
                    end else begin
                        req_cnt_q <= req_cnt_q + 3'd1;
                        mem_addr  <= {fill_base_q, req_cnt_q + 3'd1, 1'b0};
                    end
                end
                DRAIN: begin
                end
                default: state_q <= IDLE;
            endcase

            if (ret_wr) begin
                ret_cnt_q <= ret_cnt_q + 3'd1;
            end
            if (fill_done) begin
                valid_q[fill_idx] <= 1'b1;
                state_q           <= IDLE;
            end
        end
    end

    // Storage arrays carry no reset; the valid bits alone qualify their contents.
    always_ff @(posedge clk) begin
        if (ret_wr) begin
            data_q[fill_idx][ret_cnt_q] <= mem_rdata;
        end
        if (fill_done) begin
            tag_q[fill_idx] <= fill_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [15:0] access_cnt_q;
    logic [15:0] miss_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            access_cnt_q <= 16'h0000;
            miss_cnt_q   <= 16'h0000;
        end else if (state_q == IDLE && fetch_en) begin
            if (access_cnt_q != 16'hFFFF) begin
                access_cnt_q <= access_cnt_q + 16'd1;
            end
            if (!hit && miss_cnt_q != 16'hFFFF) begin
                miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    assign access_count = access_cnt_q;
    assign miss_count   = miss_cnt_q;
`else
    assign access_count = 16'h0000;
    assign miss_count   = 16'h0000;
`endif

endmodule

// File: tb/tb_instr_cache.sv
// Testbench for instr_cache: directed fetch sequences against a 4-cycle pipelined memory model.
// Expected memory requests and hit data are queued by the stimulus and popped by a monitor.
// Memory word at byte address a holds 16'hA000 + a[15:1].
module tb_instr_cache;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic [15:0] fetch_addr;
    logic [15:0] instr_out;
    logic        stall;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic [15:0] access_count;
    logic [15:0] miss_count;

    int checks = 0;
    int errors = 0;

    logic [15:0] addr_q[$];
    logic [15:0] instr_q[$];

    instr_cache #(.LINES(32), .MEM_LAT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetch_en     (fetch_en),
        .fetch_addr   (fetch_addr),
        .instr_out    (instr_out),
        .stall        (stall),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .access_count (access_count),
        .miss_count   (miss_count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return 16'hA000 + {1'b0, a[15:1]};
    endfunction

    // Fixed-latency memory: a request in cycle c returns in cycle c+4; not reset by rst_n.
    logic [3:0]  pv = 4'b0000;
    logic [15:0] pd [4];
    always @(posedge clk) begin
        pv    <= {pv[2:0], mem_rd_en};
        pd[0] <= mem_word(mem_addr);
        pd[1] <= pd[0];
        pd[2] <= pd[1];
        pd[3] <= pd[2];
    end
    assign mem_rvalid = pv[3];
    assign mem_rdata  = pd[3];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Monitor: every memory request and every hit is matched against the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_rd_en) begin
                if (addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mem_req_unexpected actual=%h required=none", mem_addr);
                end else begin
                    chk("mem_addr", mem_addr, addr_q.pop_front());
                end
            end
            if (fetch_en && !stall) begin
                if (instr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL hit_unexpected actual=%h required=none", instr_out);
                end else begin
                    chk("instr_out", instr_out, instr_q.pop_front());
                end
            end else begin
                chk("instr_zero_when_not_hit", instr_out, 16'h0000);
            end
        end
    end

    task automatic push_line(input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            addr_q.push_back(base + 16'(2 * i));
        end
    endtask

    // Issue a missing fetch, optionally redirect fetch_addr at cycle 'redir',
    // and count stall cycles until the hit appears.
    task automatic miss_fill(input logic [15:0] a, input int redir, input logic [15:0] a2,
                             input int exp_cycles, input logic [15:0] exp_instr);
        int n;
        n = 0;
        instr_q.push_back(exp_instr);
        @(posedge clk); #1;
        fetch_en   = 1'b1;
        fetch_addr = a;
        for (int c = 0; c < 60; c++) begin
            if (c == redir) fetch_addr = a2;
            #3;
            if (!stall) break;
            n++;
            @(posedge clk); #1;
        end
        chk("stall_cycles", 16'(n), 16'(exp_cycles));
    endtask

    task automatic hit(input logic [15:0] a, input logic [15:0] exp_instr);
        instr_q.push_back(exp_instr);
        @(posedge clk); #1;
        fetch_en   = 1'b1;
        fetch_addr = a;
        #3;
        chk("hit_stall", {15'd0, stall}, 16'h0000);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n    = 1'b0;
        fetch_en = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    logic [15:0] exp_acc;
    logic [15:0] exp_miss;

    initial begin
        rst_n      = 1'b0;
        fetch_en   = 1'b0;
        fetch_addr = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #3;
        chk("rst_stall", {15'd0, stall}, 16'h0000);
        chk("rst_mem_rd_en", {15'd0, mem_rd_en}, 16'h0000);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_instr", instr_out, 16'h0000);
        chk("rst_access_count", access_count, 16'h0000);
        chk("rst_miss_count", miss_count, 16'h0000);

        // Cold miss on line 0, then hits across the line.
        push_line(16'h0000, 8);
        miss_fill(16'h0000, -1, 16'h0000, 13, 16'hA000);
        for (int i = 1; i < 8; i++) begin
            hit(16'(2 * i), 16'hA000 + 16'(i));
        end

        // Conflict eviction in index 0.
        push_line(16'h0200, 8);
        miss_fill(16'h0200, -1, 16'h0200, 13, 16'hA100);
        push_line(16'h0000, 8);
        miss_fill(16'h0000, -1, 16'h0000, 13, 16'hA000);

        // Redirect at M+3: old fill completes, then a new miss on the redirected PC.
        push_line(16'h0040, 8);
        push_line(16'h0100, 8);
        miss_fill(16'h0040, 3, 16'h0100, 26, 16'hA080);
        hit(16'h0040, 16'hA020);
        hit(16'h004E, 16'hA027);

        // Reset at M+6, release at M+8; five requests go out before the abort.
        push_line(16'h0080, 5);
        @(posedge clk); #1;
        fetch_en   = 1'b1;
        fetch_addr = 16'h0080;
        repeat (6) begin
            @(posedge clk); #1;
        end
        rst_n    = 1'b0;
        fetch_en = 1'b0;
        #3;
        chk("midrst_mem_rd_en", {15'd0, mem_rd_en}, 16'h0000);
        chk("midrst_stall", {15'd0, stall}, 16'h0000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #3;
            chk("late_return_stall", {15'd0, stall}, 16'h0000);
            chk("late_return_rd_en", {15'd0, mem_rd_en}, 16'h0000);
            @(posedge clk); #1;
        end
        push_line(16'h0000, 8);
        miss_fill(16'h0000, -1, 16'h0000, 13, 16'hA000);
        push_line(16'h0080, 8);
        miss_fill(16'h0080, -1, 16'h0080, 13, 16'hA040);

        // Statistics: 3 misses (each ending in a hit cycle) plus 17 further hits.
        do_reset();
        push_line(16'h0000, 8);
        miss_fill(16'h0000, -1, 16'h0000, 13, 16'hA000);
        push_line(16'h0040, 8);
        miss_fill(16'h0040, -1, 16'h0040, 13, 16'hA020);
        push_line(16'h0080, 8);
        miss_fill(16'h0080, -1, 16'h0080, 13, 16'hA040);
        for (int i = 1; i < 8; i++) hit(16'h0000 + 16'(2 * i), 16'hA000 + 16'(i));
        for (int i = 1; i < 8; i++) hit(16'h0040 + 16'(2 * i), 16'hA020 + 16'(i));
        for (int i = 1; i < 4; i++) hit(16'h0080 + 16'(2 * i), 16'hA040 + 16'(i));
        @(posedge clk); #1;
        fetch_en = 1'b0;
        #3;
`ifdef ICACHE_STATS_EN
        exp_acc  = 16'd23;
        exp_miss = 16'd3;
`else
        exp_acc  = 16'd0;
        exp_miss = 16'd0;
`endif
        chk("access_count", access_count, exp_acc);
        chk("miss_count", miss_count, exp_miss);
        chk("idle_stall", {15'd0, stall}, 16'h0000);

        repeat (6) @(posedge clk);
        #1;
        chk("addr_queue_left", 16'(addr_q.size()), 16'h0000);
        chk("instr_queue_left", 16'(instr_q.size()), 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_cache.md
# instr_cache

Direct-mapped, read-only instruction cache between the IF-stage PC register and the multi-cycle main memory, replacing the single-cycle instruction memory on the fetch path. Hits return the instruction in the same cycle as `fetch_addr`. Misses raise `stall` and run an 8-word line fill from a fixed-latency pipelined memory, then release the pipeline.

## Interface
- `LINES`, 32: number of cache lines; index width is log2(LINES) = 5.
- `MEM_LAT`, 4: cycles from `mem_rd_en` to the matching `mem_rvalid`; the block relies on this value.
- `clk` input 1: single clock, all state on rising edge.
- `rst_n` input 1: reset is asynchronous and active-low.
- `fetch_en` input 1: fetch request this cycle.
- `fetch_addr` input 16: byte address of the instruction; bit 0 ignored.
- `instr_out` output 16: instruction on hit; 16'h0000 otherwise.
- `stall` output 1: IF must hold the PC and IF/ID register.
- `mem_rd_en` output 1: read request to main memory, one word per cycle.
- `mem_addr` output 16: word-aligned request address.
- `mem_rvalid` input 1: return data valid.
- `mem_rdata` input 16: return data, in request order.
- `access_count` output 16: fetch-access statistic (see Configuration).
- `miss_count` output 16: miss statistic (see Configuration).

## Operation
- Address split: tag = `fetch_addr[15:9]` (7b), index = `[8:4]`, word offset = `[3:1]`.
- Storage per line: valid bit, 7-bit tag, 8×16-bit data. Only valid bits are reset, to 0. Tag and data arrays are not reset.
- Hit is combinational: `fetch_en` & valid[index] & tag match & state==IDLE.
- `stall` = `fetch_en` & ~hit, or state != IDLE.
- FSM states:
  - IDLE: on `fetch_en` & miss, latch `fetch_addr[15:4]` as `fill_base`, clear `req_cnt` and `ret_cnt`, go to FILL.
  - FILL: assert `mem_rd_en` with `mem_addr` = {`fill_base`, `req_cnt`, 1'b0}. `req_cnt` increments 0..7. After issuing word 7, go to DRAIN.
  - DRAIN: no requests issued.
- In both FILL and DRAIN, each `mem_rvalid` writes `mem_rdata` into data[`fill_base` index][`ret_cnt`] and increments `ret_cnt`.
- When the 8th word is written (`ret_cnt`==7 & `mem_rvalid`), on the same edge: set the line tag, set the valid bit, go to IDLE.
- The fill completes even if `fetch_addr` or `fetch_en` change mid-fill, for example a branch flush redirecting the PC. On return to IDLE, the current `fetch_addr` is re-evaluated.
- `mem_rvalid` in IDLE is ignored and writes nothing.
- A new line overwrites the old line unconditionally; the cache is read-only, so there is no writeback.

## Timing
- Reset values: state IDLE, all valid=0, `mem_rd_en`=0, `mem_addr`=0, counters 0, `instr_out`=0. `stall` equals `fetch_en` immediately after reset (cold miss).
- Reset asserted mid-fill: immediate abort. Valid bits are cleared, including the line being filled, which is never marked valid. Memory returns still in flight arrive in IDLE and are dropped.
- Hit latency: 0 cycles, combinational from `fetch_addr`.
- Miss at cycle M (IDLE):
  - Requests issued M+1..M+8.
  - Returns arrive M+5..M+12.
  - Line valid and state IDLE from M+13.
  - `stall` is high M..M+12 and low at M+13 if the address is unchanged: 13 stall cycles.
- `mem_rd_en` is never asserted outside FILL, and is asserted for exactly 8 consecutive cycles per miss.
- `fetch_en`=0 in IDLE: `stall`=0, `instr_out`=0, no state change.

## Configuration
- `ICACHE_STATS_EN` defined:
  - `access_count` increments on each IDLE cycle with `fetch_en`=1.
  - `miss_count` increments on each IDLE→FILL transition.
  - Both saturate at 16'hFFFF and reset to 0.
- `ICACHE_STATS_EN` not defined: both ports are tied to 16'h0000, no counter flops are built, and cache behaviour is unchanged.

## Test plan
- Cold miss: reset, `fetch_addr`=16'h0000, memory word n = 16'hA000+n. Expect `stall` high 13 cycles, `mem_addr` sequence 0,2,…,E, then `instr_out`=16'hA000 with `stall`=0.
- Line hits: after the fill above, fetch 16'h0002..16'h000E on consecutive cycles. Expect `instr_out` 16'hA001..16'hA007, `stall`=0, no `mem_rd_en`.
- Conflict eviction: fetch 16'h0000, then 16'h0200 (same index 0, tag 1). Expect a second 13-cycle fill. Re-fetching 16'h0000 misses again.
- Redirect mid-fill: miss on 16'h0040, change `fetch_addr` to 16'h0100 at M+3. Expect the fill of the 16'h0040 line to complete (`mem_addr` 16'h0040..16'h004E), then an immediate new miss on 16'h0100 at M+13.
- Reset mid-fill: deassert `rst_n` at M+6, release at M+8. Expect state IDLE, returns arriving in IDLE ignored, and a re-fetch of the same address misses with a full 8-request fill.
- Stats (macro on): 3 misses + 20 hits. Expect `miss_count`=3. Expect `access_count`=23 (each miss counts once, at its IDLE cycle).
